// File: rtl/lcd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_ctrl_if                                                          |
// | Command, image-ROM and image-RAM signals of the LCD controller.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lcd_ctrl_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_ctrl                                                             |
// | 8x8 grayscale buffer: loads from IROM, runs 2x2 window commands,     |
// | dumps to IRAM on the write command.                                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lcd_ctrl (
  input  logic      clk,
  input  logic      reset,
  lcd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_IDLE   = 3'd1,
    S_EXEC   = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rom_rd_q, rom_rd_d;
  logic [5:0] rom_a_q, rom_a_d;
  logic       ram_valid_q, ram_valid_d;
  logic [5:0] ram_a_q, ram_a_d;
  logic [7:0] ram_d_q, ram_d_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic [3:0] cmd_q, cmd_d;
  logic [7:0] pix_q [64];
  logic [7:0] pix_d [64];

  logic [2:0] xm1, ym1;
  logic [5:0] a0, a1, a2, a3;
  logic [7:0] p0, p1, p2, p3;
  logic [7:0] max01, max23, pmax, min01, min23, pmin, avg;
  logic [9:0] sum;
  logic [5:0] ram_a_nxt;

  // Window corners: P0 top-left, P1 top-right, P2 bottom-left, P3 bottom-right
  always_comb begin
    xm1   = x_q - 3'd1;
    ym1   = y_q - 3'd1;
    a0    = {ym1, xm1};
    a1    = {ym1, x_q};
    a2    = {y_q, xm1};
    a3    = {y_q, x_q};
    p0    = pix_q[a0];
    p1    = pix_q[a1];
    p2    = pix_q[a2];
    p3    = pix_q[a3];
    max01 = (p0 > p1) ? p0 : p1;
    max23 = (p2 > p3) ? p2 : p3;
    pmax  = (max01 > max23) ? max01 : max23;
    min01 = (p0 < p1) ? p0 : p1;
    min23 = (p2 < p3) ? p2 : p3;
    pmin  = (min01 < min23) ? min01 : min23;
    sum   = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    avg   = sum[9:2];
    ram_a_nxt = ram_a_q + 6'd1;
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rom_rd_d    = rom_rd_q;
    rom_a_d     = rom_a_q;
    ram_valid_d = ram_valid_q;
    ram_a_d     = ram_a_q;
    ram_d_d     = ram_d_q;
    x_d         = x_q;
    y_d         = y_q;
    cmd_d       = cmd_q;
    pix_d       = pix_q;

    case (state_q)
      S_LOAD: begin
        // First cycle only raises the read; data for rom_a_q lands one edge later
        if (!rom_rd_q) begin
          rom_rd_d = 1'b1;
        end else begin
          pix_d[rom_a_q] = bus.IROM_Q;
          if (rom_a_q == 6'd63) begin
            rom_rd_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rom_a_d = rom_a_q + 6'd1;
          end
        end
      end

      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d   = bus.cmd;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        case (cmd_q)
          4'd0: begin
            busy_d      = 1'b1;
            state_d     = S_WRITE;
            ram_valid_d = 1'b1;
            ram_a_d     = 6'd0;
            ram_d_d     = pix_q[0];
          end
          4'd1: if (y_q > 3'd1) y_d = y_q - 3'd1;
          4'd2: if (y_q < 3'd7) y_d = y_q + 3'd1;
          4'd3: if (x_q > 3'd1) x_d = x_q - 3'd1;
          4'd4: if (x_q < 3'd7) x_d = x_q + 3'd1;
          4'd5: begin
            pix_d[a0] = pmax; pix_d[a1] = pmax; pix_d[a2] = pmax; pix_d[a3] = pmax;
          end
          4'd6: begin
            pix_d[a0] = pmin; pix_d[a1] = pmin; pix_d[a2] = pmin; pix_d[a3] = pmin;
          end
          4'd7: begin
            pix_d[a0] = avg; pix_d[a1] = avg; pix_d[a2] = avg; pix_d[a3] = avg;
          end
          4'd8: begin
            pix_d[a0] = p1; pix_d[a1] = p3; pix_d[a3] = p2; pix_d[a2] = p0;
          end
          4'd9: begin
            pix_d[a0] = p2; pix_d[a2] = p3; pix_d[a3] = p1; pix_d[a1] = p0;
          end
          4'd10: begin
            pix_d[a0] = p2; pix_d[a2] = p0; pix_d[a1] = p3; pix_d[a3] = p1;
          end
          4'd11: begin
            pix_d[a0] = p1; pix_d[a1] = p0; pix_d[a2] = p3; pix_d[a3] = p2;
          end
          default: ;
        endcase
      end

      S_WRITE: begin
        if (ram_a_q == 6'd63) begin
          ram_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_FINISH;
        end else begin
          ram_a_d = ram_a_nxt;
          ram_d_d = pix_q[ram_a_nxt];
        end
      end

      S_FINISH: ;

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      rom_rd_q    <= 1'b0;
      rom_a_q     <= 6'd0;
      ram_valid_q <= 1'b0;
      ram_a_q     <= 6'd0;
      ram_d_q     <= 8'd0;
      x_q         <= 3'd4;
      y_q         <= 3'd4;
      cmd_q       <= 4'd0;
      for (int i = 0; i < 64; i++) pix_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rom_rd_q    <= rom_rd_d;
      rom_a_q     <= rom_a_d;
      ram_valid_q <= ram_valid_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cmd_q       <= cmd_d;
      pix_q       <= pix_d;
    end
  end

  assign bus.IROM_rd    = rom_rd_q;
  assign bus.IROM_A     = rom_a_q;
  assign bus.IRAM_valid = ram_valid_q;
  assign bus.IRAM_A     = ram_a_q;
  assign bus.IRAM_D     = ram_d_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_ctrl                                                          |
// | Directed self-checking bench for lcd_ctrl with IROM/IRAM models.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lcd_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;
  logic [7:0] rom     [64];
  logic [7:0] ram     [64];
  logic [7:0] exp_img [64];

  lcd_ctrl_if bus_if ();

  lcd_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // ROM and RAM both act on the falling edge
  always @(negedge clk) begin
    if (bus_if.IROM_rd)    bus_if.IROM_Q <= rom[bus_if.IROM_A];
    if (bus_if.IRAM_valid) ram[bus_if.IRAM_A] <= bus_if.IRAM_D;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 64; k++) begin
      rom[k]     = 8'(k);
      exp_img[k] = 8'(k);
      ram[k]     = 8'hEE;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"},  32'(bus_if.busy), 1);
    chk({tag, "_done"},  32'(bus_if.done), 0);
    chk({tag, "_rd"},    32'(bus_if.IROM_rd), 0);
    chk({tag, "_romA"},  32'(bus_if.IROM_A), 0);
    chk({tag, "_valid"}, 32'(bus_if.IRAM_valid), 0);
    chk({tag, "_ramA"},  32'(bus_if.IRAM_A), 0);
    chk({tag, "_ramD"},  32'(bus_if.IRAM_D), 0);
  endtask

  // Called on a falling edge with reset low; releases it and waits for load end
  task automatic load_image();
    int n = 0;
    reset = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.busy && n < 200);
    chk("load_busy", 32'(bus_if.busy), 0);
    chk("load_cycles", 32'(n), 65);
    chk("load_rd_off", 32'(bus_if.IROM_rd), 0);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    int n = 0;
    bus_if.cmd       = c;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    while (bus_if.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("cmd%0d_idle", c), 32'(bus_if.busy), 0);
  endtask

  task automatic write_out(input string tag);
    int n = 0;
    int v = 0;
    bus_if.cmd       = 4'd0;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    while (!bus_if.done && n < 200) begin
      if (bus_if.IRAM_valid) v++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(bus_if.done), 1);
    chk({tag, "_valid_cycles"}, 32'(v), 64);
    repeat (3) @(negedge clk);
    chk({tag, "_done_hold"}, 32'(bus_if.done), 1);
    chk({tag, "_busy_hold"}, 32'(bus_if.busy), 1);
    chk({tag, "_valid_off"}, 32'(bus_if.IRAM_valid), 0);
    for (int k = 0; k < 64; k++)
      chk($sformatf("%s_px%0d", tag, k), 32'(ram[k]), 32'(exp_img[k]));
  endtask

  task automatic restart();
    reset            = 1'b0;
    bus_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus_if.cmd       = 4'd0;
    bus_if.cmd_valid = 1'b0;
    bus_if.IROM_Q    = 8'd0;
    set_ramp();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");

    // Plain load and dump of a ramp
    load_image();
    write_out("ramp");

    // Max at (4,4)
    set_ramp();
    restart();
    load_image();
    send_cmd(4'd5);
    exp_img[27] = 8'd36; exp_img[28] = 8'd36; exp_img[35] = 8'd36; exp_img[36] = 8'd36;
    write_out("max");

    // Saturate at (1,1), average, then min at (2,1)
    set_ramp();
    restart();
    load_image();
    repeat (5) send_cmd(4'd3);
    repeat (5) send_cmd(4'd1);
    send_cmd(4'd7);
    send_cmd(4'd4);
    send_cmd(4'd6);
    exp_img[0] = 8'd4; exp_img[8] = 8'd4;
    exp_img[1] = 8'd2; exp_img[2] = 8'd2; exp_img[9] = 8'd2; exp_img[10] = 8'd2;
    write_out("avgmin");

    // Rotate CW
    set_ramp();
    restart();
    load_image();
    send_cmd(4'd9);
    exp_img[27] = 8'd35; exp_img[28] = 8'd27; exp_img[35] = 8'd36; exp_img[36] = 8'd28;
    write_out("rotcw");

    // CCW then CW restores the window
    set_ramp();
    restart();
    load_image();
    send_cmd(4'd8);
    send_cmd(4'd9);
    write_out("rotpair");

    // Mirror X then Mirror Y
    set_ramp();
    restart();
    load_image();
    send_cmd(4'd10);
    send_cmd(4'd11);
    exp_img[27] = 8'd36; exp_img[36] = 8'd27; exp_img[28] = 8'd35; exp_img[35] = 8'd28;
    write_out("mirror");

    // cmd_valid held through busy: only the first command (shift right) runs
    set_ramp();
    restart();
    load_image();
    bus_if.cmd       = 4'd4;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    chk("hold_busy", 32'(bus_if.busy), 1);
    bus_if.cmd = 4'd2;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    chk("hold_idle", 32'(bus_if.busy), 0);
    send_cmd(4'd5);
    exp_img[28] = 8'd37; exp_img[29] = 8'd37; exp_img[36] = 8'd37; exp_img[37] = 8'd37;
    repeat (3) send_cmd(4'd4);
    repeat (4) send_cmd(4'd2);
    send_cmd(4'd7);
    exp_img[54] = 8'd58; exp_img[55] = 8'd58; exp_img[62] = 8'd58; exp_img[63] = 8'd58;
    send_cmd(4'd12);
    write_out("hold");

    // Reset in the middle of a load; ROM content changes meanwhile
    set_ramp();
    restart();
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("midload_rd", 32'(bus_if.IROM_rd), 1);
    for (int k = 0; k < 64; k++) begin
      rom[k]     = 8'((k * 3 + 7) & 8'hFF);
      exp_img[k] = 8'((k * 3 + 7) & 8'hFF);
    end
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    load_image();
    write_out("reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- 8x8, 8-bit grayscale image processing controller.
- After reset it loads 64 pixels from an external image ROM (IROM) into an internal buffer.
- It then executes a stream of 4-bit commands on a 2x2 window around a movable operation point.
- On the write command it dumps the full buffer to an external image RAM (IRAM) and asserts done.

Parameters:
- none. Fixed geometry: 8x8 image, 64 pixels, 8-bit data, address = row*8 + col.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd  input  4  command code; valid only with cmd_valid.
- cmd_valid  input  1  command strobe; honoured only when busy=0.
- IROM_rd  output  1  ROM read enable.
- IROM_A  output  6  ROM address.
- IROM_Q  input  8  ROM data. ROM registers data on the falling edge following IROM_rd/IROM_A.
- IRAM_valid  output  1  RAM write enable. RAM writes IRAM_D to IRAM_A on the falling edge.
- IRAM_D  output  8  RAM write data.
- IRAM_A  output  6  RAM write address.
- busy  output  1  high while loading, executing or writing; commands are ignored.
- done  output  1  high after the write-out completes.

Behaviour:
- Reset (reset=0): busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, operation point (x,y)=(4,4), state=LOAD.
- LOAD state:
  - IROM_rd=1; IROM_A steps 0..63, one address per cycle.
  - The address is driven at rising edge n and ROM data is valid by rising edge n+1; capture IROM_Q into buffer[address of previous cycle].
  - After pixel 63 is captured: IROM_rd=0, busy=0, go to IDLE.
- IDLE state:
  - At a rising edge with busy=0 and cmd_valid=1, latch cmd and set busy=1 on that same edge.
  - The bench drives a new command only on falling edges where busy=0.
- Operation window:
  - Pixels P0=(x-1,y-1), P1=(x,y-1), P2=(x-1,y), P3=(x,y).
  - Legal range: x,y in 1..7.
- Commands. Every non-write command finishes within 1-2 cycles, then busy=0.
  - 0 Write: go to WRITE.
  - 1 Shift up: y=y-1 if y>1, else unchanged.
  - 2 Shift down: y=y+1 if y<7.
  - 3 Shift left: x=x-1 if x>1.
  - 4 Shift right: x=x+1 if x<7.
  - 5 Max: P0..P3 all set to the maximum of the four.
  - 6 Min: P0..P3 all set to the minimum of the four.
  - 7 Average: P0..P3 all set to floor((P0+P1+P2+P3)/4); compute the sum at 10 bits.
  - 8 Rotate CCW: new P0=P1, P1=P3, P3=P2, P2=P0.
  - 9 Rotate CW: new P0=P2, P2=P3, P3=P1, P1=P0.
  - 10 Mirror X: swap P0<->P2 and P1<->P3.
  - 11 Mirror Y: swap P0<->P1 and P2<->P3.
  - 12-15: no-op; busy returns to 0.
  - Shifts at a boundary leave the point unchanged. Pixel operations never alter the point.
- WRITE state:
  - IRAM_valid=1 for 64 consecutive cycles, with IRAM_A=k and IRAM_D=buffer[k], k=0..63.
  - At the rising edge after the k=63 cycle: IRAM_valid=0, done=1.
  - busy remains 1. The block stays in FINISH with done=1 until reset.
- Reset mid-operation: all state returns to reset values and LOAD restarts from address 0.
- Priority: reset overrides all. cmd_valid while busy=1 is ignored.

Test Plan:
- Reset then load a ramp image (pixel k = k) with commands 0 -> IRAM[k]=k for all k; done rises after exactly 64 valid cycles.
- Point (4,4), cmd 5, then 0 -> addresses 27,28,35,36 all equal the max of the original values; the rest are unchanged.
- Cmd 3 issued 5 times, then cmd 1 issued 5 times, then cmd 7, then 0 -> point saturates at (1,1); addresses 0,1,8,9 = floor(sum/4). For ramp values 0,1,8,9 the result is 4.
- Ramp image, cmd 9 at (4,4) -> IRAM[27]=35, [28]=27, [35]=36, [36]=28. Cmd 8 then cmd 9 restores the original values.
- Cmd 10 then cmd 11 at (4,4) -> net 180-degree swap: [27]<->[36] and [28]<->[35].
- Hold cmd_valid=1 while busy -> no extra commands execute; assert reset mid-LOAD -> load restarts and the final image is still correct.
